// File: rtl/tacho.sv
// rtl/tacho.sv - fan tachometer: gated tach edge counter with CSR result and stall irq
// Optional glitch filter on the tach input is enabled by defining TACHO_FILTER_EN.
module tacho #(
   parameter logic [4:0] BASE_ADDR = 5'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   input  logic       gate_ce,
   input  logic       tach_in,
   output logic       irq
);

   logic        sel_ctrl, sel_stat, sel_rh, sel_rl;
   logic        ctrl_wr, stat_wr;

   logic        sync1_q, sync2_q;
   logic        tach_f, tach_prev_q, edge_pulse;

   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic [1:0]  scale_q, scale_d;
   logic        valid_q, valid_d;
   logic        stall_q, stall_d;
   logic        ovf_q, ovf_d;
   logic [15:0] result_q, result_d;
   logic [15:0] edge_cnt_q, edge_cnt_d;
   logic [2:0]  win_q, win_d;
   logic        irq_q, irq_d;

   logic [2:0]  win_last;
   logic        win_end;
   logic [16:0] edge_sum;
   logic [15:0] edge_sat;
   logic [2:0]  stat_clr;

   assign sel_ctrl = (csr_a == BASE_ADDR);
   assign sel_stat = (csr_a == BASE_ADDR + 5'd1);
   assign sel_rh   = (csr_a == BASE_ADDR + 5'd2);
   assign sel_rl   = (csr_a == BASE_ADDR + 5'd3);
   assign ctrl_wr  = csr_we & sel_ctrl;
   assign stat_wr  = csr_we & sel_stat;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         tach_prev_q <= 1'b0;
      end else begin
         sync1_q     <= tach_in;
         sync2_q     <= sync1_q;
         tach_prev_q <= tach_f;
      end
   end

`ifdef TACHO_FILTER_EN
   // tach_f follows the synchronized input only after 4 stable cycles at the new level
   logic [1:0] stab_q;
   logic       tach_f_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stab_q   <= 2'd0;
         tach_f_q <= 1'b0;
      end else if (sync2_q != tach_f_q) begin
         if (stab_q == 2'd3) begin
            tach_f_q <= sync2_q;
            stab_q   <= 2'd0;
         end else begin
            stab_q <= stab_q + 2'd1;
         end
      end else begin
         stab_q <= 2'd0;
      end
   end

   assign tach_f = tach_f_q;
`else
   assign tach_f = sync2_q;
`endif

   assign edge_pulse = tach_f & ~tach_prev_q;

   assign edge_sum = {1'b0, edge_cnt_q} + {16'd0, edge_pulse};
   assign edge_sat = edge_sum[16] ? 16'hFFFF : edge_sum[15:0];

   always_comb begin
      case (scale_q)
         2'd0:    win_last = 3'd0;
         2'd1:    win_last = 3'd1;
         2'd2:    win_last = 3'd3;
         default: win_last = 3'd7;
      endcase
   end

   // A CTRL write in the window-end cycle suppresses the latch entirely
   assign win_end  = en_q & gate_ce & ~ctrl_wr & (win_q == win_last);
   assign stat_clr = stat_wr ? csr_di[2:0] : 3'd0;

   always_comb begin
      en_d       = en_q;
      ie_d       = ie_q;
      scale_d    = scale_q;
      result_d   = result_q;
      valid_d    = valid_q & ~stat_clr[0];
      stall_d    = stall_q & ~stat_clr[1];
      ovf_d      = ovf_q   & ~stat_clr[2];
      edge_cnt_d = edge_sat;
      win_d      = win_q + {2'd0, gate_ce};
      irq_d      = stall_q & ie_q;

      if (ctrl_wr) begin
         en_d    = csr_di[7];
         ie_d    = csr_di[6];
         scale_d = csr_di[1:0];
      end

      if (!en_q || ctrl_wr) begin
         edge_cnt_d = 16'd0;
         win_d      = 3'd0;
      end else if (win_end) begin
         edge_cnt_d = 16'd0;
         win_d      = 3'd0;
         result_d   = edge_sat;
         valid_d    = 1'b1;
         if (edge_sat == 16'hFFFF) ovf_d = 1'b1;
         if (edge_sat == 16'd0) stall_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         scale_q    <= 2'd0;
         valid_q    <= 1'b0;
         stall_q    <= 1'b0;
         ovf_q      <= 1'b0;
         result_q   <= 16'd0;
         edge_cnt_q <= 16'd0;
         win_q      <= 3'd0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         ie_q       <= ie_d;
         scale_q    <= scale_d;
         valid_q    <= valid_d;
         stall_q    <= stall_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         edge_cnt_q <= edge_cnt_d;
         win_q      <= win_d;
         irq_q      <= irq_d;
      end
   end

   assign irq = irq_q;

   always_comb begin
      csr_do = 8'h00;
      if (sel_ctrl)
         csr_do = {en_q, ie_q, 4'b0000, scale_q};
      else if (sel_stat)
         csr_do = {5'b00000, ovf_q, stall_q, valid_q};
      else if (sel_rh)
         csr_do = result_q[15:8];
      else if (sel_rl)
         csr_do = result_q[7:0];
   end

endmodule

// File: tb/tb_tacho.sv
// tb/tb_tacho.sv - directed self-checking bench for tacho
module tb_tacho;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;
   logic       gate_ce;
   logic       tach_in;
   logic       irq;

   int total = 0;
   int bad   = 0;

   tacho #(.BASE_ADDR(5'h0)) dut (
      .clk     (clk),
      .rst     (rst),
      .csr_a   (csr_a),
      .csr_di  (csr_di),
      .csr_we  (csr_we),
      .csr_do  (csr_do),
      .gate_ce (gate_ce),
      .tach_in (tach_in),
      .irq     (irq)
   );

   always #10 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
      csr_a = a;
      #1;
      chk(tag, {8'h00, csr_do}, {8'h00, exp});
   endtask

   task automatic chk_result(input string tag, input logic [15:0] exp);
      logic [15:0] r;
      csr_a = 5'd2;
      #1;
      r[15:8] = csr_do;
      csr_a = 5'd3;
      #1;
      r[7:0] = csr_do;
      chk(tag, r, exp);
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      chk(tag, {15'd0, irq}, {15'd0, exp});
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      cycles(1);
      csr_we = 1'b0;
   endtask

   task automatic wr_gate(input logic [4:0] a, input logic [7:0] d);
      csr_a   = a;
      csr_di  = d;
      csr_we  = 1'b1;
      gate_ce = 1'b1;
      cycles(1);
      csr_we  = 1'b0;
      gate_ce = 1'b0;
   endtask

   task automatic gate();
      gate_ce = 1'b1;
      cycles(1);
      gate_ce = 1'b0;
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         tach_in = 1'b1;
         cycles(hi);
         tach_in = 1'b0;
         cycles(lo);
      end
   endtask

   initial begin
      logic [15:0] filt_exp;
`ifdef TACHO_FILTER_EN
      filt_exp = 16'h0014;
`else
      filt_exp = 16'h0028;
`endif
      rst = 1'b1; csr_a = 5'd0; csr_di = 8'h00; csr_we = 1'b0;
      gate_ce = 1'b0; tach_in = 1'b0;
      cycles(3);
      rst = 1'b0;

      chk_reg("reset_ctrl", 5'd0, 8'h00);
      chk_reg("reset_status", 5'd1, 8'h00);
      chk_result("reset_result", 16'h0000);
      chk_irq("reset_irq", 1'b0);

      wr(5'd0, 8'hFF);
      chk_reg("ctrl_readback", 5'd0, 8'hC3);
      chk_reg("unmapped_4", 5'd4, 8'h00);
      chk_reg("unmapped_31", 5'd31, 8'h00);

      // basic count, scale 0
      wr(5'd0, 8'h80);
      gate();
      wr(5'd1, 8'h07);
      pulses(100, 8, 8);
      cycles(6);
      gate();
      chk_result("basic_result", 16'h0064);
      chk_reg("basic_status", 5'd1, 8'h01);
      cycles(1);
      chk_irq("basic_irq", 1'b0);

      // scale 2: four ticks per window
      wr(5'd1, 8'h07);
      wr(5'd0, 8'h82);
      for (int t = 0; t < 4; t++) begin
         pulses(10, 8, 8);
         cycles(6);
         gate();
         if (t < 3) begin
            chk_reg("scale_status_early", 5'd1, 8'h00);
            chk_result("scale_result_early", 16'h0064);
         end else begin
            chk_result("scale_result", 16'h0028);
            chk_reg("scale_status", 5'd1, 8'h01);
         end
      end

      // stall interrupt
      wr(5'd1, 8'h07);
      wr(5'd0, 8'hC0);
      gate();
      chk_reg("stall_status", 5'd1, 8'h03);
      chk_irq("stall_irq_n1", 1'b0);
      cycles(1);
      chk_irq("stall_irq_n2", 1'b1);
      wr(5'd1, 8'h02);
      chk_reg("stall_cleared", 5'd1, 8'h01);
      chk_irq("stall_irq_lag", 1'b1);
      cycles(1);
      chk_irq("stall_irq_drop", 1'b0);
      wr_gate(5'd1, 8'h02);
      chk_reg("stall_set_wins", 5'd1, 8'h03);
      cycles(1);
      chk_irq("stall_irq_again", 1'b1);

      // glitches interleaved with clean pulses
      wr(5'd1, 8'h07);
      wr(5'd0, 8'h80);
      for (int i = 0; i < 20; i++) begin
         pulses(1, 3, 8);
         pulses(1, 8, 8);
      end
      cycles(6);
      gate();
      chk_result("filter_result", filt_exp);
      chk_irq("filter_irq_off", 1'b0);

      // CTRL write mid-window discards earlier edges
      wr(5'd1, 8'h07);
      pulses(5, 8, 8);
      wr(5'd0, 8'h80);
      pulses(7, 8, 8);
      cycles(6);
      gate();
      chk_result("restart_result", 16'h0007);
      chk_reg("restart_status", 5'd1, 8'h01);

      // CTRL write coinciding with window end
      wr(5'd1, 8'h07);
      pulses(3, 8, 8);
      cycles(6);
      wr_gate(5'd0, 8'h80);
      chk_reg("ctrlwin_status", 5'd1, 8'h00);
      chk_result("ctrlwin_result", 16'h0007);
      gate();
      chk_result("ctrlwin_next", 16'h0000);
      chk_reg("ctrlwin_next_st", 5'd1, 8'h03);

      // disabled: no counting, result retained
      wr(5'd1, 8'h07);
      wr(5'd0, 8'h00);
      pulses(4, 8, 8);
      cycles(6);
      gate();
      chk_reg("dis_status", 5'd1, 8'h00);
      chk_result("dis_result", 16'h0000);

      // rst mid-window
      wr(5'd0, 8'hC0);
      pulses(2, 8, 8);
      cycles(6);
      gate();
      chk_result("prerst_result", 16'h0002);
      wr(5'd0, 8'hC0);
      gate();
      cycles(1);
      chk_irq("prerst_irq", 1'b1);
      wr(5'd0, 8'hC1);
      pulses(3, 8, 8);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      chk_reg("rst_ctrl", 5'd0, 8'h00);
      chk_reg("rst_status", 5'd1, 8'h00);
      chk_result("rst_result", 16'h0000);
      chk_irq("rst_irq", 1'b0);
      gate();
      cycles(2);
      chk_reg("rst_after_gate", 5'd1, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
